// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding and
// the counter-width helper used by the top and the bit divider.
package seq_pattern_tx_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
  localparam logic [1:0] ST_GAP_ENC   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_SHIFT = ST_SHIFT_ENC,
    ST_GAP   = ST_GAP_ENC
  } state_t;

  // Bits needed to hold the values 0..n (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_tx_bit_tick_div.sv
// DIV-cycle divider: counts 0..DIV-1 while enabled and raises tick on the
// last count of each bit period. clr holds the count at zero.
module bit_tick_div
  import seq_pattern_tx_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Divider count: cleared while idle, wraps at the end of each bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: takes a word over valid/ready, shifts it out
// MSB-first with each bit held DIV clocks, forces a GAP*DIV low gap, and
// reports the number of 0->1 transitions it put on the line for that frame.
module seq_pattern_tx
  import seq_pattern_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1,
  parameter int GAP   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic                       sdo,
  output logic                       sdo_active,
  output logic                       frame_done,
  output logic [$clog2(WIDTH+1)-1:0] rise_cnt
);

  localparam int RC_W  = $clog2(WIDTH + 1);
  localparam int IDX_W = cnt_width((WIDTH > GAP) ? WIDTH : GAP);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_GAP = IDX_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state, state_nxt;
  logic             accept;
  logic             tick;
  logic             at_last_bit;
  logic             at_last_gap;
  logic [IDX_W-1:0] idx;        // bit index in SHIFT, gap period index in GAP
  logic [WIDTH-2:0] pend;       // bits still to be sent after the one on sdo
  logic [RC_W-1:0]  acc;

  assign din_ready   = (state == ST_IDLE);
  assign accept      = din_valid && din_ready;
  assign at_last_bit = (idx == LAST_BIT);
  assign at_last_gap = (GAP > 0) && (idx == LAST_GAP);

  bit_tick_div #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state != ST_IDLE),
    .clr  (accept || (state == ST_IDLE)),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: frame runs WIDTH bit periods, then an optional gap.
  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt; no latch.
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: if (tick && at_last_bit) state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:   if (tick && at_last_gap) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, shift at bit boundaries, publish count at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      idx        <= '0;
      acc        <= '0;
      sdo        <= 1'b0;
      sdo_active <= 1'b0;
      frame_done <= 1'b0;
      rise_cnt   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values; the
      // rise test below relies on sdo still holding the outgoing bit.
      frame_done <= 1'b0;
      if (accept) begin
        pend       <= din[WIDTH-2:0];
        sdo        <= din[WIDTH-1];
        sdo_active <= 1'b1;
        idx        <= '0;
        // The line is always low before a frame, so a leading 1 is a rise.
        acc        <= RC_W'(din[WIDTH-1]);
      end else if (state == ST_SHIFT && tick) begin
        if (at_last_bit) begin
          sdo        <= 1'b0;
          sdo_active <= 1'b0;
          frame_done <= 1'b1;
          rise_cnt   <= acc;
          idx        <= '0;
        end else begin
          sdo  <= pend[WIDTH-2];
          pend <= pend << 1;
          idx  <= idx + 1'b1;
          if (pend[WIDTH-2] && !sdo) acc <= acc + 1'b1;
        end
      end else if (state == ST_GAP && tick) begin
        idx <= at_last_gap ? '0 : idx + 1'b1;
      end
    end
  end

endmodule
